spi_register_bridge: RTL and testbench

SPI_REGISTER_BRIDGE -- requirements
Module: spi_register_bridge

---
 rtl/spi_register_bridge.sv | 132 +++++++++++++
 tb/tb_spi_register_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_register_bridge.sv
// SPI (mode 0) slave that turns 32-bit frames into register writes.
// Frame layout: {number[15:0], value[15:0]}, MSB first. All inputs are resynchronised to i_Clock.
module spi_register_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SPI_Clock,
  input  logic        i_SPI_MOSI,
  input  logic        i_SPI_ChipSelect_n,
  output logic [15:0] o_RegisterNumber,
  output logic [15:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable,
  output logic        o_FrameError
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit,
    StDrain
  } state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_prev;
  logic                   r_armed;
  state_e                 r_state;
  logic [5:0]             r_bit_cnt;
  logic [31:0]            r_shift;
  logic [15:0]            r_number;
  logic [15:0]            r_value;
  logic                   r_frame_error;

  logic                   w_sclk;
  logic                   w_mosi;
  logic                   w_cs;
  logic                   w_rise;
  state_e                 w_state_d;
  logic [5:0]             w_bit_cnt_d;
  logic [31:0]            w_shift_d;
  logic                   w_abort;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_prev;

  // Identical depth on all three inputs keeps MOSI aligned with the detected clock edge.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_fill      <= '0;
      r_sclk_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPI_Clock};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SPI_ChipSelect_n};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      // The chain resets to "deselected", so only trust a high CS once real samples fill it.
      r_armed     <= r_armed | (r_fill[SYNC_STAGES-1] & w_cs);
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_abort     = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_armed && !w_cs) begin
          w_state_d   = StShift;
          w_bit_cnt_d = '0;
          w_shift_d   = '0;
        end
      end
      StShift: begin
        // The 32nd edge wins over a simultaneous CS release.
        if (w_rise && (r_bit_cnt == 6'd31)) begin
          w_shift_d   = {r_shift[30:0], w_mosi};
          w_bit_cnt_d = 6'd32;
          w_state_d   = StCommit;
        end else if (w_cs) begin
          w_state_d = StIdle;
          w_abort   = (r_bit_cnt != 6'd0);
        end else if (w_rise) begin
          w_shift_d   = {r_shift[30:0], w_mosi};
          w_bit_cnt_d = r_bit_cnt + 6'd1;
        end
      end
      StCommit: w_state_d = StDrain;
      StDrain: begin
        if (w_cs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state       <= StIdle;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_number      <= '0;
      r_value       <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_bit_cnt     <= w_bit_cnt_d;
      r_shift       <= w_shift_d;
      r_frame_error <= w_abort;
      // Load on entry so the data is already valid in the strobe cycle.
      if (w_state_d == StCommit) begin
        r_number <= w_shift_d[31:16];
        r_value  <= w_shift_d[15:0];
      end
    end
  end

  assign o_RegisterNumber      = r_number;
  assign o_RegisterValue       = r_value;
  assign o_RegisterWriteEnable = (r_state == StCommit);
  assign o_FrameError          = r_frame_error;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Scoreboard bench for spi_register_bridge: directed SPI frames push expected writes/errors,
// a monitor pops and compares on every strobe or error pulse.
module tb_spi_register_bridge;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [15:0] reg_num;
  logic [15:0] reg_val;
  logic        reg_we;
  logic        frame_err;

  typedef struct packed {
    logic        is_err;
    logic [15:0] num;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  spi_register_bridge #(
    .SYNC_STAGES(2)
  ) dut (
    .i_Clock              (clk),
    .i_Reset_n            (rst_n),
    .i_SPI_Clock          (sclk),
    .i_SPI_MOSI           (mosi),
    .i_SPI_ChipSelect_n   (cs_n),
    .o_RegisterNumber     (reg_num),
    .o_RegisterValue      (reg_val),
    .o_RegisterWriteEnable(reg_we),
    .o_FrameError         (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe or error pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (reg_we || frame_err)) begin
      exp_t e;
      if (reg_we && frame_err) begin
        check("strobe_and_error_together", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_event(we,err)", {30'd0, reg_we, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("write_number", {16'd0, reg_num}, {16'd0, e.num});
          check("write_value", {16'd0, reg_val}, {16'd0, e.val});
        end
      end
    end
  end

  // SPI clock = clk/8; cs_last raises CS together with the final rising edge.
  task automatic send_bits(input logic [63:0] data, input int nbits, input bit release_cs,
                           input bit cs_last);
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (cs_last && (i == nbits - 1)) cs_n = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    if (release_cs) cs_n = 1'b1;
  endtask

  task automatic push_write(input logic [15:0] num, input logic [15:0] val);
    exp_t e;
    e.is_err = 1'b0;
    e.num    = num;
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.num    = '0;
    e.val    = '0;
    exp_q.push_back(e);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_number", {16'd0, reg_num}, 32'd0);
    check("reset_value", {16'd0, reg_val}, 32'd0);
    check("reset_we_err", {30'd0, reg_we, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Plain frame.
    push_write(16'h0102, 16'hABCD);
    send_bits(64'h0102ABCD, 32, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // Abort after 20 bits; previous outputs must be held.
    push_err();
    send_bits(64'hFFFFF, 20, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("held_number_after_abort", {16'd0, reg_num}, 32'h0102);
    check("held_value_after_abort", {16'd0, reg_val}, 32'hABCD);

    // 40 bits; trailing 8 must be ignored.
    push_write(16'h2000, 16'h0001);
    send_bits({32'h20000001, 8'hFF}, 40, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // Back-to-back frames with CS high for 4 cycles.
    push_write(16'h1100, 16'h0001);
    push_write(16'h1101, 16'h0005);
    send_bits(64'h11000001, 32, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_bits(64'h11010005, 32, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // Reset at bit 17; release reset with CS still low, then further clocks must be ignored.
    send_bits(64'h1FFFF, 17, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_number", {16'd0, reg_num}, 32'd0);
    check("midreset_value", {16'd0, reg_val}, 32'd0);
    check("midreset_we_err", {30'd0, reg_we, frame_err}, 32'd0);
    rst_n = 1'b1;
    send_bits(64'hFFFFFFFF, 32, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("no_write_before_cs_high", {16'd0, reg_num}, 32'd0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    push_write(16'h3102, 16'h0200);
    send_bits(64'h31020200, 32, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // CS rises together with the 32nd edge.
    push_write(16'h5A5A, 16'hC3C3);
    send_bits(64'h5A5AC3C3, 32, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_number", {16'd0, reg_num}, 32'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
